key_event_queue: RTL and testbench
==================================

# key_event_queue

Buffers keyboard events produced by the PS/2 keyboard decoder (key_valid / last_change / key_down) into a small FIFO of self-describing event words, so game and UI logic can consume key presses and releases at its own pace over a ready/valid port. Each event records the 9-bit key code, press/release direction, and whether it is a typematic repeat. The block sits directly downstream of the keyboard decoder, in the same clock domain.

## Interface
- DEPTH, 8, number of FIFO entries; power of two, 2..64
- AW, 3, log2(DEPTH)
- FILTER_REPEAT, 1, 1 = drop typematic repeat presses; 0 = enqueue them with repeat flag set
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- key_valid  input  1  one-cycle pulse from decoder: key_down / last_change just updated
- last_change  input  9  {extend, scan code} of the key that changed
- key_down  input  512  decoder key-state vector, already updated in the key_valid cycle
- ev_data  output  11  head event {repeat, pressed, code[8:0]}
- ev_valid  output  1  FIFO non-empty; ev_data is meaningful
- ev_ready  input  1  consumer accepts head event when ev_valid && ev_ready
- count  output  AW+1  entries currently held, 0..DEPTH
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- clr_overflow  input  1  clears overflow

## Operation
- Shadow register key_down_q <= key_down every cycle; reset 0.
- In a cycle with key_valid = 1, form the event:
  - pressed = key_down[last_change]; 1 = make, 0 = break.
  - repeat = pressed && key_down_q[last_change]; the key was already down.
  - code = last_change.
- Event is discarded when repeat = 1 and FILTER_REPEAT = 1. Discarded repeats never set overflow.
- Push condition: event not discarded and (count < DEPTH, or pop in the same cycle).
- Event not discarded, count = DEPTH, no pop: event is dropped and overflow <= 1.
- Pop condition: ev_valid && ev_ready.
- Storage: register array mem[DEPTH], write pointer wp and read pointer rp, each AW bits.
  - Pointers wrap modulo DEPTH.
  - count increments on push-only, decrements on pop-only, and holds on push+pop or on no operation.
- First-word-fall-through:
  - ev_data = mem[rp], combinational from registers.
  - ev_valid = (count != 0).
  - ev_data is don't-care while ev_valid = 0; the bench must not check it then.
- Overflow flag:
  - clr_overflow = 1 clears it.
  - If a set and a clear occur in the same cycle, the set wins.
- Outputs at reset: ev_valid = 0, count = 0, overflow = 0, wp = rp = 0, key_down_q = 0. mem contents need no reset.
- Reset asserted mid-operation: queued events are lost immediately and asynchronously. Operation resumes on the first clock edge after rst returns to 1.

## Timing
- Enqueue latency 1 cycle: key_valid sampled at edge N makes ev_valid / count reflect the event after edge N.
- Pop takes effect at the edge where ev_valid && ev_ready. The next entry appears on ev_data after that edge, with no bubble.
- Push into an empty FIFO with ev_ready held high: ev_valid is 1 for exactly 1 cycle, then the event is popped.
- Full FIFO with pop and key_valid in the same cycle: both happen, count stays DEPTH, no overflow.
- Empty FIFO with key_valid and ev_ready in the same cycle: push only; no pop, because ev_valid was 0.
- Throughput: one push and one pop per cycle maximum. The decoder emits at most one key_valid per PS/2 frame, far below that rate.
- No combinational path from key_valid to ev_valid; the only combinational output path is ev_ready-independent.

## Test plan
- Reset check: hold rst = 0 → ev_valid = 0, count = 0, overflow = 0. Release rst, wait 5 cycles → outputs unchanged.
- Make/break:
  - key_valid with last_change = 9'h01C, key_down[0x1C] = 1 (key_down_q bit 0) → ev_data = 11'b0_1_000011100.
  - Later, key_valid with bit cleared → ev_data = 11'b0_0_000011100.
  - Both events are read in order.
- Repeat handling:
  - FILTER_REPEAT = 1: press 0x1C twice without release → count = 1.
  - FILTER_REPEAT = 0: same stimulus → second event ev_data = 11'b1_1_000011100.
  - In both cases overflow = 0.
- Overflow:
  - With ev_ready = 0, push 9 distinct presses into DEPTH = 8 → count = 8 and overflow = 1.
  - Drain → codes come out in order 1..8; the ninth code is absent.
  - Pulse clr_overflow → overflow = 0.
- Simultaneous events:
  - Full FIFO with ev_ready = 1 and key_valid in the same cycle → count stays 8, overflow = 0, new event appears last.
  - clr_overflow coincident with a dropped push → overflow stays 1.
- Wrap-around / async reset:
  - Stream 20 events with ev_ready toggling randomly → output order matches input order across pointer wrap.
  - Assert rst mid-stream between edges → ev_valid and count go to 0 before the next edge.

Source files
------------

// File: rtl/key_event_queue.sv
// Key event FIFO: turns decoder key_valid pulses into {repeat, pressed, code} words
// and serves them first-word-fall-through over a ready/valid port.
module key_event_queue #(
  parameter int DEPTH         = 8,
  parameter int AW            = 3,
  parameter int FILTER_REPEAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [8:0]    last_change,
  input  logic [511:0]  key_down,
  output logic [10:0]   ev_data,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_overflow
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [511:0] r_keyDownQ;
  logic [10:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]  r_count;
  logic         r_overflow;

  logic w_pressed;
  logic w_repeat;
  logic w_discard;
  logic w_event;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A press whose key was already down last cycle is a typematic repeat.
  assign w_pressed = key_down[last_change];
  assign w_repeat  = w_pressed & r_keyDownQ[last_change];
  assign w_discard = w_repeat & (FILTER_REPEAT != 0);
  assign w_event   = key_valid & ~w_discard;
  assign w_full    = (r_count == FULL_COUNT);
  assign w_pop     = ev_valid & ev_ready;
  assign w_push    = w_event & (~w_full | w_pop);
  assign w_drop    = w_event & w_full & ~w_pop;

  assign ev_valid  = (r_count != '0);
  assign ev_data   = r_mem[r_rp];
  assign count     = r_count;
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= {w_repeat, w_pressed, last_change};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_keyDownQ <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_keyDownQ <= key_down;
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: one instance filters repeats, a second
// instance keeps them, each with its own expected-event queue and monitor.
module tb_key_event_queue;

  logic          clk;
  logic          rst;
  logic          key_valid;
  logic [8:0]    last_change;
  logic [511:0]  key_down;
  logic          clr_overflow;
  logic          ev_ready;
  logic          readyB;
  logic          enB;
  logic          kvB;

  logic [10:0]   evDataA, evDataB;
  logic          evValidA, evValidB;
  logic [3:0]    countA, countB;
  logic          ovfA, ovfB;

  logic [511:0]  keyState;
  logic [10:0]   qA[$];
  logic [10:0]   qB[$];
  int            checks;
  int            errors;

  assign kvB = key_valid & enB;

  key_event_queue #(.DEPTH(8), .AW(3), .FILTER_REPEAT(1)) dutA (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .ev_data(evDataA), .ev_valid(evValidA), .ev_ready(ev_ready),
    .count(countA), .overflow(ovfA), .clr_overflow(clr_overflow)
  );

  key_event_queue #(.DEPTH(8), .AW(3), .FILTER_REPEAT(0)) dutB (
    .clk(clk), .rst(rst), .key_valid(kvB), .last_change(last_change),
    .key_down(key_down), .ev_data(evDataB), .ev_valid(evValidB), .ev_ready(readyB),
    .count(countB), .overflow(ovfB), .clr_overflow(clr_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitors: every accepted head event must match the oldest expected event.
  always @(negedge clk) begin
    if (rst && evValidA && ev_ready) begin
      checks++;
      if (qA.size() == 0) begin
        errors++;
        $display("[TB] FAIL popA: got %h, required none (scoreboard empty)", evDataA);
      end else begin
        logic [10:0] expA;
        expA = qA.pop_front();
        if (evDataA !== expA) begin
          errors++;
          $display("[TB] FAIL popA: got %h, required %h", evDataA, expA);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && evValidB && readyB) begin
      checks++;
      if (qB.size() == 0) begin
        errors++;
        $display("[TB] FAIL popB: got %h, required none (scoreboard empty)", evDataB);
      end else begin
        logic [10:0] expB;
        expB = qB.pop_front();
        if (evDataB !== expB) begin
          errors++;
          $display("[TB] FAIL popB: got %h, required %h", evDataB, expB);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One key_valid cycle; expected events are pushed to the scoreboards up front.
  task automatic applyStimulus(input logic [8:0] code, input logic down,
                               input logic pushA, input logic [10:0] evA,
                               input logic pushB, input logic [10:0] evB,
                               input logic clr);
    keyState[code] = down;
    key_down       = keyState;
    last_change    = code;
    key_valid      = 1'b1;
    clr_overflow   = clr;
    if (pushA) qA.push_back(evA);
    if (pushB) qB.push_back(evB);
    @(posedge clk);
    #1;
    key_valid    = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic drainA();
    int k;
    k = 0;
    ev_ready = 1'b1;
    while (countA != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    ev_ready = 1'b0;
    checkOutput("drainA_timeout", (k < 50), 1);
    checkOutput("drainA_sbEmpty", qA.size(), 0);
  endtask

  task automatic drainB();
    int k;
    k = 0;
    readyB = 1'b1;
    while (countB != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    readyB = 1'b0;
    checkOutput("drainB_timeout", (k < 50), 1);
    checkOutput("drainB_sbEmpty", qB.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    keyState     = '0;
    key_down     = '0;
    key_valid    = 1'b0;
    last_change  = '0;
    clr_overflow = 1'b0;
    ev_ready     = 1'b0;
    readyB       = 1'b0;
    enB          = 1'b0;
    rst          = 1'b1;
    #2 rst = 1'b0;

    // Reset state, then five idle cycles after release.
    stepCycles(3);
    checkOutput("rst_valid", evValidA, 0);
    checkOutput("rst_count", countA, 0);
    checkOutput("rst_ovf", ovfA, 0);
    rst = 1'b1;
    stepCycles(5);
    checkOutput("idle_valid", evValidA, 0);
    checkOutput("idle_count", countA, 0);
    checkOutput("idle_ovf", ovfA, 0);

    // Make then break of 0x1C, read back in order.
    applyStimulus(9'h01C, 1'b1, 1'b1, 11'b0_1_000011100, 1'b0, '0, 1'b0);
    checkOutput("make_valid", evValidA, 1);
    checkOutput("make_data", evDataA, 11'b0_1_000011100);
    stepCycles(1);
    applyStimulus(9'h01C, 1'b0, 1'b1, 11'b0_0_000011100, 1'b0, '0, 1'b0);
    checkOutput("makebreak_count", countA, 2);
    drainA();

    // Repeat press: filtered in A, flagged in B.
    enB = 1'b1;
    applyStimulus(9'h01C, 1'b1, 1'b1, 11'b0_1_000011100, 1'b1, 11'b0_1_000011100, 1'b0);
    stepCycles(1);
    applyStimulus(9'h01C, 1'b1, 1'b0, '0, 1'b1, 11'b1_1_000011100, 1'b0);
    checkOutput("rptA_count", countA, 1);
    checkOutput("rptB_count", countB, 2);
    checkOutput("rptA_ovf", ovfA, 0);
    checkOutput("rptB_ovf", ovfB, 0);
    enB = 1'b0;
    applyStimulus(9'h01C, 1'b0, 1'b1, 11'b0_0_000011100, 1'b0, '0, 1'b0);
    drainA();
    drainB();

    // Overflow: codes 1..8 fill the FIFO, code 9 is dropped.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(9'(i), 1'b1, 1'b1, {2'b01, 9'(i)}, 1'b0, '0, 1'b0);
    end
    checkOutput("full_count", countA, 8);
    checkOutput("full_ovf", ovfA, 0);
    applyStimulus(9'd9, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("ovf_count", countA, 8);
    checkOutput("ovf_set", ovfA, 1);
    applyStimulus(9'd10, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("ovf_setWinsClr", ovfA, 1);
    clr_overflow = 1'b1;
    stepCycles(1);
    clr_overflow = 1'b0;
    checkOutput("ovf_cleared", ovfA, 0);

    // Full FIFO: push and pop together keep count at 8 with no overflow.
    ev_ready = 1'b1;
    applyStimulus(9'd11, 1'b1, 1'b1, {2'b01, 9'd11}, 1'b0, '0, 1'b0);
    ev_ready = 1'b0;
    checkOutput("simul_count", countA, 8);
    checkOutput("simul_ovf", ovfA, 0);
    drainA();

    // Twenty events with random ready, wrapping both pointers.
    for (int i = 0; i < 20; i++) begin
      ev_ready = 1'($urandom_range(0, 1));
      applyStimulus(9'h040 + 9'(i), 1'b1, 1'b1, {2'b01, 9'h040 + 9'(i)}, 1'b0, '0, 1'b0);
      ev_ready = 1'($urandom_range(0, 1));
      stepCycles(1);
      ev_ready = 1'b1;
      stepCycles(1);
    end
    drainA();

    // Asynchronous reset between edges discards queued events at once.
    applyStimulus(9'h060, 1'b1, 1'b1, {2'b01, 9'h060}, 1'b0, '0, 1'b0);
    applyStimulus(9'h061, 1'b1, 1'b1, {2'b01, 9'h061}, 1'b0, '0, 1'b0);
    applyStimulus(9'h062, 1'b1, 1'b1, {2'b01, 9'h062}, 1'b0, '0, 1'b0);
    checkOutput("prerst_count", countA, 3);
    #2 rst = 1'b0;
    #1;
    checkOutput("asyncrst_valid", evValidA, 0);
    checkOutput("asyncrst_count", countA, 0);
    qA.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    stepCycles(1);
    applyStimulus(9'h063, 1'b1, 1'b1, {2'b01, 9'h063}, 1'b0, '0, 1'b0);
    checkOutput("postrst_count", countA, 1);
    drainA();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
